// File: rtl/user_io_spi_gen.sv
// Oversampled SPI side channel on CONF_DATA0: buttons, NUM_JOY joystick words and a paced kbd/mouse FIFO.
// Build option USER_IO_STATUS_EN adds a 32-bit status port loaded by command 0x15.
module user_io_spi_gen #(
  parameter int         NUM_JOY    = 2,
  parameter int         JOY_W      = 6,
  parameter logic [7:0] CORE_TYPE  = 8'hA1,
  parameter int         FIFO_DEPTH = 8,
  parameter int         STROBE_GAP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_sck,
  input  logic                     spi_ss,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [7:0]               buttons,
  output logic [NUM_JOY*JOY_W-1:0] joy,
  output logic [7:0]               kbd_mouse_data,
  output logic [1:0]               kbd_mouse_type,
  output logic                     kbd_mouse_strobe,
`ifdef USER_IO_STATUS_EN
  output logic [31:0]              status,
`endif
  output logic                     fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_PAYLOAD = 2'd2} state_t;

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic ss_meta_q, ss_sync_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sck_rise_s, sck_fall_s, ss_low_s;

  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] miso_sr_q, miso_sr_d;
  logic       miso_q, miso_d;
  logic [7:0] cmd_q, cmd_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       dispatch_s;

  logic [7:0]               buttons_q, buttons_d;
  logic [NUM_JOY*JOY_W-1:0] joy_q, joy_d;
  logic [31:0]              status_q, status_d;
  logic                     push_s, ovf_clr_s;
  logic [9:0]               push_data_s;

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        full_s, empty_s, pop_s, push_ok_s;
  logic        ovf_q, ovf_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  kd_q, kd_d;
  logic [1:0]  kt_q, kt_d;
  logic        stb_q, stb_d;

  // Two-flop synchronisers; chip select idles high so spi_miso_oe resets low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ss_meta_q   <= spi_ss;
      ss_sync_q   <= ss_meta_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise_s = sck_sync_q & ~sck_prev_q;
  assign sck_fall_s = ~sck_sync_q & sck_prev_q;
  assign ss_low_s   = ~ss_sync_q;
  assign dispatch_s = (state_q == ST_PAYLOAD) && byte_done_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ss_low_s ? ST_CMD : ST_IDLE;
      ST_CMD:     state_d = !ss_low_s ? ST_IDLE : (byte_done_q ? ST_PAYLOAD : ST_CMD);
      ST_PAYLOAD: state_d = ss_low_s ? ST_PAYLOAD : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: MISO carries the id byte only while in CMD.
  always_comb begin
    miso_d = 1'b0;
    case (state_d)
      ST_CMD:  miso_d = miso_sr_d[7];
      default: miso_d = 1'b0;
    endcase
  end

  // Bit shifting, byte framing and command/byte-index tracking.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    miso_sr_d   = miso_sr_q;
    cmd_d       = cmd_q;
    byte_idx_d  = byte_idx_q;
    if (!ss_low_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise_s) begin
      shift_d     = {shift_q[6:0], mosi_sync_q};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      byte_done_d = (bit_cnt_q == 3'd7);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if (state_q == ST_IDLE && ss_low_s) begin
      miso_sr_d = CORE_TYPE;
    end else if (state_q == ST_CMD && sck_fall_s) begin
      miso_sr_d = {miso_sr_q[6:0], 1'b0};
    end else begin
      miso_sr_d = miso_sr_q;
    end
    if (state_q == ST_CMD && byte_done_q) begin
      cmd_d = shift_q;
    end else begin
      cmd_d = cmd_q;
    end
    if (!ss_low_s) begin
      byte_idx_d = 3'd0;
    end else if (state_q == ST_CMD && byte_done_q) begin
      byte_idx_d = 3'd0;
    end else if (dispatch_s && byte_idx_q != 3'd7) begin
      byte_idx_d = byte_idx_q + 3'd1;
    end else begin
      byte_idx_d = byte_idx_q;
    end
  end

  // Payload dispatch on (cmd, byte_idx).
  always_comb begin
    buttons_d   = buttons_q;
    joy_d       = joy_q;
    status_d    = status_q;
    push_s      = 1'b0;
    push_data_s = 10'd0;
    ovf_clr_s   = 1'b0;
    if (dispatch_s) begin
      case (cmd_q)
        8'h01: buttons_d = (byte_idx_q == 3'd0) ? shift_q : buttons_q;
        8'h04: begin
          case (byte_idx_q)
            3'd0:    begin push_s = 1'b1; push_data_s = {2'd0, shift_q}; end
            3'd1:    begin push_s = 1'b1; push_data_s = {2'd1, shift_q}; end
            3'd2:    begin push_s = 1'b1; push_data_s = {2'd3, shift_q}; end
            default: push_s = 1'b0;
          endcase
        end
        8'h05: begin
          push_s      = 1'b1;
          push_data_s = {2'd2, shift_q};
        end
        8'h06: ovf_clr_s = 1'b1;
`ifdef USER_IO_STATUS_EN
        8'h15: begin
          if (byte_idx_q[2] == 1'b0) status_d[{byte_idx_q[1:0], 3'b000} +: 8] = shift_q;
          else                       status_d = status_q;
        end
`endif
        default: begin
          for (int n = 0; n < NUM_JOY; n++) begin
            joy_d[n*JOY_W +: JOY_W] = (byte_idx_q == 3'd0 && cmd_q == (8'h10 + 8'(n)))
                                      ? shift_q[JOY_W-1:0] : joy_q[n*JOY_W +: JOY_W];
          end
        end
      endcase
    end else begin
      buttons_d = buttons_q;
    end
  end

  // A push into a full FIFO still lands if a pop frees a slot in the same cycle.
  always_comb begin
    full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_s   = (wptr_q == rptr_q);
    pop_s     = !empty_s && (gap_q == 8'd0);
    push_ok_s = push_s && (!full_s || pop_s);
    wptr_d    = wptr_q + {{AW{1'b0}}, push_ok_s};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop_s};
    if (ovf_clr_s)                    ovf_d = 1'b0;
    else if (push_s && full_s && !pop_s) ovf_d = 1'b1;
    else                              ovf_d = ovf_q;
    if (pop_s)               gap_d = 8'(STROBE_GAP - 1);
    else if (gap_q != 8'd0)  gap_d = gap_q - 8'd1;
    else                     gap_d = gap_q;
    stb_d = pop_s;
    if (pop_s) begin
      kd_d = mem_q[rptr_q[AW-1:0]][7:0];
      kt_d = mem_q[rptr_q[AW-1:0]][9:8];
    end else begin
      kd_d = kd_q;
      kt_d = kt_q;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wptr_q[AW-1:0]] <= push_data_s;
    else           mem_q[wptr_q[AW-1:0]] <= mem_q[wptr_q[AW-1:0]];
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      miso_sr_q   <= 8'd0;
      miso_q      <= 1'b0;
      cmd_q       <= 8'd0;
      byte_idx_q  <= 3'd0;
      buttons_q   <= 8'd0;
      joy_q       <= '0;
      status_q    <= 32'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      gap_q       <= 8'd0;
      kd_q        <= 8'd0;
      kt_q        <= 2'd0;
      stb_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
      cmd_q       <= cmd_d;
      byte_idx_q  <= byte_idx_d;
      buttons_q   <= buttons_d;
      joy_q       <= joy_d;
      status_q    <= status_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      gap_q       <= gap_d;
      kd_q        <= kd_d;
      kt_q        <= kt_d;
      stb_q       <= stb_d;
    end
  end

  assign spi_miso         = miso_q;
  assign spi_miso_oe      = ss_low_s;
  assign buttons          = buttons_q;
  assign joy              = joy_q;
  assign kbd_mouse_data   = kd_q;
  assign kbd_mouse_type   = kt_q;
  assign kbd_mouse_strobe = stb_q;
  assign fifo_overflow    = ovf_q;
`ifdef USER_IO_STATUS_EN
  assign status           = status_q;
`else
  logic unused_status_s;
  assign unused_status_s  = ^status_q;
`endif

endmodule

// File: tb/tb_user_io_spi_gen.sv
// Directed bench for user_io_spi_gen (NUM_JOY=4, JOY_W=6, FIFO_DEPTH=4, STROBE_GAP=255).
`timescale 1ns/1ps
module tb_user_io_spi_gen;

  logic        clk = 1'b0;
  logic        rst, spi_sck, spi_ss, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  buttons;
  logic [23:0] joy;
  logic [7:0]  kbd_mouse_data;
  logic [1:0]  kbd_mouse_type;
  logic        kbd_mouse_strobe;
  logic        fifo_overflow;
`ifdef USER_IO_STATUS_EN
  logic [31:0] status;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hp    = 80;

  typedef struct { int cyc; logic [1:0] t; logic [7:0] d; } ev_t;
  ev_t evq[$];

  user_io_spi_gen #(
    .NUM_JOY(4), .JOY_W(6), .CORE_TYPE(8'hA1), .FIFO_DEPTH(4), .STROBE_GAP(255)
  ) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .buttons(buttons), .joy(joy),
    .kbd_mouse_data(kbd_mouse_data), .kbd_mouse_type(kbd_mouse_type),
    .kbd_mouse_strobe(kbd_mouse_strobe),
`ifdef USER_IO_STATUS_EN
    .status(status),
`endif
    .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (kbd_mouse_strobe === 1'b1) evq.push_back('{cyc, kbd_mouse_type, kbd_mouse_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #hp;
      r[i] = spi_miso;
      spi_sck = 1'b1;
      #hp;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic cs_low();
    spi_ss = 1'b0;
    #200;
  endtask

  task automatic cs_high();
    #100;
    spi_ss = 1'b1;
    #200;
  endtask

  task automatic xfer2(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    cs_low();
    spi_byte(c, r);
    spi_byte(d, r);
    cs_high();
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1; spi_sck = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
    #20;
    chk("rst_buttons", {24'd0, buttons}, 32'h0);
    chk("rst_joy", {8'd0, joy}, 32'h0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'h0);
    chk("rst_miso", {31'd0, spi_miso}, 32'h0);
    chk("rst_strobe", {31'd0, kbd_mouse_strobe}, 32'h0);
    chk("rst_ovf", {31'd0, fifo_overflow}, 32'h0);
    rst = 1'b0;
    #100;

    // cmd 0x01 + 0xA5, MISO returns the core id during the command byte
    hp = 80;
    cs_low();
    chk("oe_cs_low", {31'd0, spi_miso_oe}, 32'h1);
    spi_byte(8'h01, r);
    chk("miso_core_type", {24'd0, r}, 32'hA1);
    spi_byte(8'hA5, r);
    chk("miso_payload_zero", {24'd0, r}, 32'h00);
    cs_high();
    chk("buttons_a5", {24'd0, buttons}, 32'hA5);
    chk("oe_cs_high", {31'd0, spi_miso_oe}, 32'h0);

    // joystick words; word 4 does not exist
    hp = 20;
    xfer2(8'h12, 8'hFF);
    xfer2(8'h14, 8'h3C);
    chk("joy_word2", {8'd0, joy}, 32'h0003F000);
    xfer2(8'h13, 8'h2A);
    chk("joy_word3", {8'd0, joy}, 32'h00ABF000);

    // mouse packet: three strobes paced STROBE_GAP apart
    evq.delete();
    cs_low();
    spi_byte(8'h04, r);
    spi_byte(8'h05, r);
    spi_byte(8'hFB, r);
    spi_byte(8'h01, r);
    spi_byte(8'h77, r);
    cs_high();
    #10000;
    chk("mouse_cnt", evq.size(), 32'd3);
    if (evq.size() >= 3) begin
      chk("mouse0", {22'd0, evq[0].t, evq[0].d}, {22'd0, 2'd0, 8'h05});
      chk("mouse1", {22'd0, evq[1].t, evq[1].d}, {22'd0, 2'd1, 8'hFB});
      chk("mouse2", {22'd0, evq[2].t, evq[2].d}, {22'd0, 2'd3, 8'h01});
      chk("gap01", evq[1].cyc - evq[0].cyc, 32'd255);
      chk("gap12", evq[2].cyc - evq[1].cyc, 32'd255);
    end

    // keyboard burst overflows a 4-deep FIFO
    evq.delete();
    cs_low();
    spi_byte(8'h05, r);
    spi_byte(8'h11, r);
    spi_byte(8'h22, r);
    spi_byte(8'h33, r);
    spi_byte(8'h44, r);
    spi_byte(8'h55, r);
    spi_byte(8'h66, r);
    cs_high();
    chk("ovf_set", {31'd0, fifo_overflow}, 32'h1);
    chk("kbd_first_cnt", evq.size(), 32'd1);
    #12000;
    chk("kbd_cnt", evq.size(), 32'd5);
    if (evq.size() >= 5) begin
      chk("kbd0", {22'd0, evq[0].t, evq[0].d}, {22'd0, 2'd2, 8'h11});
      chk("kbd1", {22'd0, evq[1].t, evq[1].d}, {22'd0, 2'd2, 8'h22});
      chk("kbd2", {22'd0, evq[2].t, evq[2].d}, {22'd0, 2'd2, 8'h33});
      chk("kbd3", {22'd0, evq[3].t, evq[3].d}, {22'd0, 2'd2, 8'h44});
      chk("kbd4", {22'd0, evq[4].t, evq[4].d}, {22'd0, 2'd2, 8'h55});
    end
    xfer2(8'h06, 8'h00);
    chk("ovf_clear", {31'd0, fifo_overflow}, 32'h0);
    chk("ovf_clear_no_push", evq.size(), 32'd5);

    // chip select raised mid-payload discards the partial byte
    cs_low();
    spi_byte(8'h01, r);
    spi_bits(8'hFF, 5, r);
    cs_high();
    chk("partial_keep", {24'd0, buttons}, 32'hA5);
    xfer2(8'h01, 8'h3C);
    chk("buttons_3c", {24'd0, buttons}, 32'h3C);

    // status command
    cs_low();
    spi_byte(8'h15, r);
    spi_byte(8'h78, r);
    spi_byte(8'h56, r);
    spi_byte(8'h34, r);
    spi_byte(8'h12, r);
    cs_high();
`ifdef USER_IO_STATUS_EN
    chk("status_word", status, 32'h12345678);
    xfer2(8'h15, 8'hAA);
    chk("status_byte0", status, 32'h123456AA);
`else
    chk("st_buttons", {24'd0, buttons}, 32'h3C);
    chk("st_joy", {8'd0, joy}, 32'h00ABF000);
    chk("st_no_push", evq.size(), 32'd5);
    chk("st_ovf", {31'd0, fifo_overflow}, 32'h0);
`endif

    // async reset in the middle of a command byte
    cs_low();
    spi_bits(8'h01, 4, r);
    chk("pre_rst_oe", {31'd0, spi_miso_oe}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_buttons", {24'd0, buttons}, 32'h0);
    chk("arst_joy", {8'd0, joy}, 32'h0);
    chk("arst_kdata", {24'd0, kbd_mouse_data}, 32'h0);
    chk("arst_ktype", {30'd0, kbd_mouse_type}, 32'h0);
    chk("arst_strobe", {31'd0, kbd_mouse_strobe}, 32'h0);
    chk("arst_miso", {31'd0, spi_miso}, 32'h0);
    chk("arst_oe", {31'd0, spi_miso_oe}, 32'h0);
    chk("arst_ovf", {31'd0, fifo_overflow}, 32'h0);
    #6;
    spi_ss = 1'b1;
    spi_sck = 1'b0;
    #100;
    rst = 1'b0;
    #100;
    xfer2(8'h01, 8'h5A);
    chk("post_rst_buttons", {24'd0, buttons}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/user_io_spi_gen.md
Name: user_io_spi_gen

Overview:
- Parametrised successor to the fixed two-joystick user_io SPI side channel. Decodes host (ARM IO controller) commands on the CONF_DATA0 chip select.
- Delivers buttons, NUM_JOY joystick words and a buffered keyboard/mouse byte stream to the core; returns CORE_TYPE on MISO.
- SPI is oversampled in the system clock domain, so the core sees one synchronous interface.
- Sits in the board top between the SPI pins and Minimig1.

Parameters:
- NUM_JOY, 2, number of joystick channels, 1..4.
- JOY_W, 6, bits per joystick word, 1..8; taken from the low bits of the payload byte.
- CORE_TYPE, 8'hA1, core id byte shifted out during every command byte.
- FIFO_DEPTH, 8, keyboard/mouse FIFO entries; power of two, 2..32.
- STROBE_GAP, 4, minimum clk cycles between kbd_mouse_strobe pulses; 1..255.

Ports:
- clk  in  1  system clock; must be at least 4x spi_sck.
- rst  in  1  asynchronous active-high reset.
- spi_sck  in  1  SPI clock, mode 0, idle low.
- spi_ss  in  1  chip select, active low (CONF_DATA0).
- spi_mosi  in  1  host-to-core data.
- spi_miso  out  1  core-to-host data.
- spi_miso_oe  out  1  high while spi_ss_sync is low; top muxes or tristates SPI_DO with it.
- buttons  out  8  switch/button byte.
- joy  out  NUM_JOY*JOY_W  joystick n at [n*JOY_W +: JOY_W], active high.
- kbd_mouse_data  out  8  popped FIFO byte.
- kbd_mouse_type  out  2  0 = mouse X, 1 = mouse Y, 2 = keyboard, 3 = mouse buttons.
- kbd_mouse_strobe  out  1  one-cycle pulse; data and type are valid in the same cycle.
- fifo_overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Synchronisation: spi_sck, spi_ss and spi_mosi each pass through 2 flops. SCK rise/fall detected from the synced copies.
- Sampling:
  - Rising edge: shift mosi into an 8-bit shift register MSB first and increment the 3-bit bit_cnt.
  - When bit_cnt wraps 7->0, a byte is complete; it is acted on in the next clk cycle.
  - Net latency from the pin SCK edge to a register update is 3 clk cycles.
- State machine:
  - IDLE: spi_ss_sync high. On its falling edge go to CMD and load miso_sr with CORE_TYPE.
  - CMD: on byte complete, latch cmd and go to PAYLOAD with byte_idx = 0.
  - PAYLOAD: each completed byte is dispatched on (cmd, byte_idx), then byte_idx increments, saturating at 7.
  - Any state: spi_ss_sync high returns to IDLE. The partial byte is discarded, and bit_cnt and byte_idx are cleared.
- MISO:
  - In CMD, spi_miso = miso_sr[7]; miso_sr shifts left on each SCK falling edge.
  - In PAYLOAD/IDLE, spi_miso = 0.
  - The first bit (CORE_TYPE[7]) is valid before the first rising edge.
- Command dispatch:
  - 0x01, byte 0: buttons <= byte.
  - 0x10+n, n<NUM_JOY, byte 0: joy word n <= byte[JOY_W-1:0]. For n>=NUM_JOY the byte is ignored.
  - 0x04: byte 0 pushes {0,byte}, byte 1 pushes {1,byte}, byte 2 pushes {3,byte}; later bytes are ignored.
  - 0x05: every payload byte pushes {2,byte}.
  - 0x06: clears fifo_overflow; payload ignored.
  - Any other command: payload ignored, no state change.
- FIFO:
  - FIFO_DEPTH x 10 bits, with read/write pointers one bit wider than the index.
  - Full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
  - Push when full: the byte is dropped and fifo_overflow is set. Stored contents are untouched.
  - Pop: when not empty and gap_cnt == 0, present the head on kbd_mouse_data/type, pulse kbd_mouse_strobe and load gap_cnt = STROBE_GAP-1.
  - Simultaneous push and pop in one cycle are both honoured; a push is accepted even when full if a pop happens in the same cycle.
  - First strobe follows the push by exactly 1 cycle when gap_cnt is 0.
- Reset (async, any state, including mid-transfer):
  - Registers: state IDLE, buttons 0, joy all 0, FIFO empty, fifo_overflow 0, gap_cnt 0.
  - Outputs: kbd_mouse_data 0, kbd_mouse_type 0, kbd_mouse_strobe 0, spi_miso 0.
  - Synchroniser reset values: spi_ss 1, the others 0, so spi_miso_oe resets to 0.

Optional Feature:
- Macro: USER_IO_STATUS_EN.
- Defined:
  - Adds port status (out, 32 bits, reset 0) and command 0x15.
  - Payload bytes 0..3 load status[7:0], [15:8], [23:16], [31:24] respectively.
  - Each byte updates individually at its own completion; bytes not sent keep their value.
- Undefined: no status port; 0x15 is treated as an unknown command.

Test Plan:
- Reset, then a CS-low transfer of cmd 0x01 + 0xA5 -> MISO returns 0xA1 during the cmd byte, buttons = 0xA5, spi_miso_oe high only while CS is low.
- NUM_JOY=4, JOY_W=6: cmd 0x12 + 0xFF, then cmd 0x14 + 0x3C -> joy[17:12] = 6'h3F, all other words unchanged (0).
- Cmd 0x04 + 0x05,0xFB,0x01 -> three strobes, type/data 0/0x05, 1/0xFB, 3/0x01, separated by exactly STROBE_GAP cycles.
- FIFO_DEPTH=4, STROBE_GAP=255: cmd 0x05 with 6 bytes -> first byte popped, 4 stored, 1 dropped, fifo_overflow = 1; then cmd 0x06 -> fifo_overflow = 0.
- CS raised after 5 bits of a 0x01 payload, then a full 0x01 + 0x3C -> buttons = 0x3C, never a partial value. Async rst asserted mid-byte -> all outputs return to reset values within the same cycle.
- USER_IO_STATUS_EN defined: cmd 0x15 + 0x78,0x56,0x34,0x12 -> status = 0x12345678. Undefined: same transfer produces no output change.
